sm_color_sensor_ctrl: RTL and testbench
=======================================

// Module: sm_color_sensor_ctrl
// PURPOSE
//  Upstream stage of the RGB LED indicator block. Drives the TCS3200 colour sensor filter selects
//  and counts sensor output edges over a fixed window for each of the red, green and blue filters.
//  Classifies the soil patch colour and presents it as a stable 2-bit code on color[1:0]
//  (00 none, 01 red, 10 blue, 11 green), which is wired directly to the LED indicator's color input.
// PARAMETERS
//  SETTLE_CYCLES  5000   clk cycles ignored after each filter change (100 us at 50 MHz)
//  WINDOW_CYCLES  50000  clk cycles per edge-count window (1 ms at 50 MHz)
//  COUNT_W        16     width of each edge counter; counters saturate at 2^COUNT_W-1
//  THRESH         20     a winning count below this classifies as 00 (no colour)
//  CONFIRM        3      consecutive identical candidates required before color updates (>=1)
// PORTS
//  clk          in   1        system clock, rising edge
//  rst          in   1        asynchronous, active-high reset
//  enable       in   1        1 = run sweeps; 0 = abort and idle
//  sensor_out   in   1        TCS3200 OUT, asynchronous square wave
//  s0, s1       out  1        frequency scaling; constant 1,0 (20%)
//  s2, s3       out  1        filter select: 00 red, 11 green, 01 blue
//  color        out  2        confirmed colour code
//  color_valid  out  1        1-cycle pulse when color changes value
//  red_cnt, green_cnt, blue_cnt  out  COUNT_W  last completed window counts (debug)
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, phase=R, {s2,s3}=00, s0=1, s1=0, color=00, color_valid=0,
//   all counts/match counter/candidate = 0. Synchroniser flops cleared.
//  sensor_out: 2-flop synchroniser then rising-edge detect (q1 & ~q2); 2-cycle input latency.
//  FSM states IDLE, SETTLE, MEASURE, DECIDE; phase order R -> G -> B.
//   IDLE: {s2,s3}=00. enable=1 -> SETTLE(phase R), timer=0.
//   SETTLE: {s2,s3} per phase; edges ignored; after exactly SETTLE_CYCLES cycles -> MEASURE, edge cnt=0.
//   MEASURE: edge cnt +1 per detected edge, saturating; after exactly WINDOW_CYCLES cycles store cnt
//    into phase register; phase R->G or G->B goes to SETTLE; phase B goes to DECIDE.
//   DECIDE (1 cycle): cand = colour of max(R,G,B); ties resolved R > G > B; if max < THRESH cand=00.
//    cand == prev cand -> match=min(match+1,CONFIRM) else match=1; prev=cand.
//    match reaches CONFIRM and cand != color -> color<=cand, color_valid=1 for this cycle only.
//    Then SETTLE with phase R (continuous sweeps while enable=1).
//  Sweep latency: 3*(SETTLE_CYCLES+WINDOW_CYCLES)+1 cycles; color changes at earliest
//   CONFIRM sweeps after a new colour is presented.
//  enable=0 in any non-IDLE state: next edge -> IDLE, phase=R, match=0, prev=00, color<=00
//   (color_valid pulses if color was non-zero); debug counts retain last values.
//  Held color is stable between decisions; no glitching on color during SETTLE/MEASURE.
//  An edge arriving on the cycle MEASURE ends is not counted; SETTLE/MEASURE edge cases counted by timer only.
// TESTING (SETTLE_CYCLES=4, WINDOW_CYCLES=40, THRESH=5, CONFIRM=2, COUNT_W=8 unless stated)
//  1 Red dominant: R 10 edges, G 4, B 3 per window, 2 sweeps -> color=01 at 2nd DECIDE, one color_valid pulse,
//    s2s3 sequence 00,11,01 with 44-cycle spacing.
//  2 Threshold/ties: all counts 3 -> color stays 00, no pulse; R=G=8,B=2 -> 01; G=B=9,R=1 -> 11.
//  3 Flicker: candidates alternate green/blue each sweep for 6 sweeps -> color never changes from 00.
//  4 Saturation (COUNT_W=4): 18 edges in R window -> red_cnt=15, no wrap to 2.
//  5 Abort: enable drops mid-MEASURE of phase G with color=11 -> next cycle IDLE, s2s3=00, color=00,
//    one color_valid pulse; re-enable restarts at SETTLE phase R.
//  6 Async rst asserted between clock edges during DECIDE -> all outputs at reset values immediately.

Source files
------------

// File: rtl/sm_color_sensor_ctrl_if.sv
// Colour sensor controller port bundle: sensor drive/capture on one side, colour result on the other.
interface sm_color_sensor_ctrl_if #(
  parameter int COUNT_W = 16
);
  logic               enable;
  logic               sensor_out;
  logic               s0;
  logic               s1;
  logic               s2;
  logic               s3;
  logic [1:0]         color;
  logic               color_valid;
  logic [COUNT_W-1:0] red_cnt;
  logic [COUNT_W-1:0] green_cnt;
  logic [COUNT_W-1:0] blue_cnt;

  modport master (
    output enable, sensor_out,
    input  s0, s1, s2, s3, color, color_valid, red_cnt, green_cnt, blue_cnt
  );

  modport slave (
    input  enable, sensor_out,
    output s0, s1, s2, s3, color, color_valid, red_cnt, green_cnt, blue_cnt
  );
endinterface

// File: rtl/sm_color_sensor_ctrl.sv
// TCS3200 sweep controller: settle/count R,G,B windows, classify, debounce into a held 2-bit colour.
// One sweep takes 3*(SETTLE_CYCLES+WINDOW_CYCLES)+1 cycles; no backpressure, color is a level output.
module sm_color_sensor_ctrl #(
  parameter int SETTLE_CYCLES = 5000,
  parameter int WINDOW_CYCLES = 50000,
  parameter int COUNT_W       = 16,
  parameter int THRESH        = 20,
  parameter int CONFIRM       = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  sm_color_sensor_ctrl_if.slave bus
);
  localparam int TMAX = (SETTLE_CYCLES > WINDOW_CYCLES) ? SETTLE_CYCLES : WINDOW_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int MW   = $clog2(CONFIRM + 1);

  localparam logic [TW-1:0]      SETTLE_LAST = TW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0]      WINDOW_LAST = TW'(WINDOW_CYCLES - 1);
  localparam logic [COUNT_W-1:0] CNT_MAX     = '1;
  localparam logic [COUNT_W-1:0] THRESH_C    = COUNT_W'(THRESH);
  localparam logic [MW-1:0]      CONFIRM_C   = MW'(CONFIRM);

  localparam logic [1:0] C_NONE  = 2'b00;
  localparam logic [1:0] C_RED   = 2'b01;
  localparam logic [1:0] C_BLUE  = 2'b10;
  localparam logic [1:0] C_GREEN = 2'b11;

  typedef enum logic [1:0] {IDLE, SETTLE, MEASURE, DECIDE} state_t;
  // Phase encoding doubles as the {s2,s3} filter select.
  typedef enum logic [1:0] {PH_R = 2'b00, PH_G = 2'b11, PH_B = 2'b01} phase_t;

  state_t             state_q, state_d;
  phase_t             phase_q, phase_d;
  logic [TW-1:0]      timer_q, timer_d;
  logic [COUNT_W-1:0] cnt_q, cnt_d;
  logic [COUNT_W-1:0] red_q, red_d, green_q, green_d, blue_q, blue_d;
  logic [COUNT_W-1:0] max_cnt;
  logic [1:0]         prev_q, prev_d, color_q, color_d, cand;
  logic [MW-1:0]      match_q, match_d, match_nx;
  logic               valid_q, valid_d;
  logic               sync0_q, q1_q, q2_q, edge_det;

  assign edge_det = q1_q & ~q2_q;

  always_comb begin
    max_cnt = red_q;
    cand    = C_RED;
    if (red_q >= green_q && red_q >= blue_q) begin
      max_cnt = red_q;
      cand    = C_RED;
    end else if (green_q >= blue_q) begin
      max_cnt = green_q;
      cand    = C_GREEN;
    end else begin
      max_cnt = blue_q;
      cand    = C_BLUE;
    end
    if (max_cnt < THRESH_C) cand = C_NONE;
    match_nx = MW'(1);
    if (cand == prev_q) match_nx = (match_q == CONFIRM_C) ? match_q : match_q + MW'(1);
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    timer_d = timer_q;
    cnt_d   = cnt_q;
    red_d   = red_q;
    green_d = green_q;
    blue_d  = blue_q;
    prev_d  = prev_q;
    match_d = match_q;
    color_d = color_q;
    valid_d = 1'b0;
    if (state_q != IDLE && !bus.enable) begin
      // Abort drops the held colour but keeps the debug counts.
      state_d = IDLE;
      phase_d = PH_R;
      match_d = '0;
      prev_d  = C_NONE;
      color_d = C_NONE;
      valid_d = (color_q != C_NONE);
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.enable) begin
            state_d = SETTLE;
            phase_d = PH_R;
            timer_d = '0;
          end
        end
        SETTLE: begin
          if (timer_q == SETTLE_LAST) begin
            state_d = MEASURE;
            timer_d = '0;
            cnt_d   = '0;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
        MEASURE: begin
          if (timer_q == WINDOW_LAST) begin
            timer_d = '0;
            case (phase_q)
              PH_R: begin
                red_d   = cnt_q;
                phase_d = PH_G;
                state_d = SETTLE;
              end
              PH_G: begin
                green_d = cnt_q;
                phase_d = PH_B;
                state_d = SETTLE;
              end
              default: begin
                blue_d  = cnt_q;
                state_d = DECIDE;
              end
            endcase
          end else begin
            timer_d = timer_q + TW'(1);
            if (edge_det && cnt_q != CNT_MAX) cnt_d = cnt_q + COUNT_W'(1);
          end
        end
        DECIDE: begin
          prev_d  = cand;
          match_d = match_nx;
          if (match_nx == CONFIRM_C && cand != color_q) begin
            color_d = cand;
            valid_d = 1'b1;
          end
          state_d = SETTLE;
          phase_d = PH_R;
          timer_d = '0;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      phase_q <= PH_R;
      timer_q <= '0;
      cnt_q   <= '0;
      red_q   <= '0;
      green_q <= '0;
      blue_q  <= '0;
      prev_q  <= C_NONE;
      match_q <= '0;
      color_q <= C_NONE;
      valid_q <= 1'b0;
      sync0_q <= 1'b0;
      q1_q    <= 1'b0;
      q2_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      timer_q <= timer_d;
      cnt_q   <= cnt_d;
      red_q   <= red_d;
      green_q <= green_d;
      blue_q  <= blue_d;
      prev_q  <= prev_d;
      match_q <= match_d;
      color_q <= color_d;
      valid_q <= valid_d;
      sync0_q <= bus.sensor_out;
      q1_q    <= sync0_q;
      q2_q    <= q1_q;
    end
  end

  assign bus.s0          = 1'b1;
  assign bus.s1          = 1'b0;
  assign {bus.s2, bus.s3} = (state_q == IDLE) ? 2'b00 : phase_q;
  assign bus.color       = color_q;
  assign bus.color_valid = valid_q;
  assign bus.red_cnt     = red_q;
  assign bus.green_cnt   = green_q;
  assign bus.blue_cnt    = blue_q;
endmodule

// File: tb/tb_sm_color_sensor_ctrl.sv
// Bench for sm_color_sensor_ctrl: sweep-timeline model checked every cycle plus directed literal checks.
module tb_sm_color_sensor_ctrl;
  localparam int S     = 4;
  localparam int W     = 40;
  localparam int CW    = 8;
  localparam int TH    = 5;
  localparam int CF    = 2;
  localparam int SW    = S + W;
  localparam int SWEEP = 3 * SW + 1;
  localparam int CMAX  = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sm_color_sensor_ctrl_if #(.COUNT_W(CW)) bus ();
  sm_color_sensor_ctrl_if #(.COUNT_W(4))  bus4 ();
  assign bus4.enable     = bus.enable;
  assign bus4.sensor_out = bus.sensor_out;

  sm_color_sensor_ctrl #(.SETTLE_CYCLES(S), .WINDOW_CYCLES(W), .COUNT_W(CW), .THRESH(TH), .CONFIRM(CF))
    u_dut (.clk(clk), .rst(rst), .bus(bus));
  sm_color_sensor_ctrl #(.SETTLE_CYCLES(S), .WINDOW_CYCLES(W), .COUNT_W(4), .THRESH(TH), .CONFIRM(CF))
    u_dut4 (.clk(clk), .rst(rst), .bus(bus4));

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Intended edge counts of the sweep in flight, published by the stimulus.
  int cur_r = 0, cur_g = 0, cur_b = 0;

  // Model state
  bit running = 0;
  int t = 0;
  int exp_col = 0, exp_vld = 0, exp_r = 0, exp_g = 0, exp_b = 0;
  int hist[$];
  int pulse_total = 0;

  function automatic int sat(input int n);
    return (n > CMAX) ? CMAX : n;
  endfunction

  function automatic int cand_of(input int r, input int g, input int b);
    int mx = r;
    if (g > mx) mx = g;
    if (b > mx) mx = b;
    if (mx < TH) return 0;
    if (r == mx) return 1;
    if (g == mx) return 3;
    return 2;
  endfunction

  task automatic decide();
    int c = cand_of(exp_r, exp_g, exp_b);
    bit same;
    hist.push_back(c);
    if (hist.size() > CF) void'(hist.pop_front());
    same = (hist.size() == CF);
    foreach (hist[i]) if (hist[i] != c) same = 0;
    if (same && c != exp_col) begin
      exp_col = c;
      exp_vld = 1;
    end
  endtask

  initial begin
    bit en_s, rst_s;
    int off, sel;
    forever begin
      @(posedge clk);
      en_s  = bus.enable;
      rst_s = rst;
      @(negedge clk);
      exp_vld = 0;
      if (rst || rst_s) begin
        running = 0; t = 0; exp_col = 0; exp_r = 0; exp_g = 0; exp_b = 0;
        hist.delete();
      end else if (running && !en_s) begin
        running = 0;
        hist.delete();
        if (exp_col != 0) exp_vld = 1;
        exp_col = 0;
      end else if (running) begin
        t++;
        off = t % SWEEP;
        if (off == SW)         exp_r = sat(cur_r);
        if (off == 2 * SW)     exp_g = sat(cur_g);
        if (off == 3 * SW)     exp_b = sat(cur_b);
        if (off == 0)          decide();
      end else if (en_s) begin
        running = 1;
        t = 0;
      end
      off = t % SWEEP;
      sel = !running ? 0 : (off / SW == 0) ? 0 : (off / SW == 1) ? 3 : 1;
      chk("color", bus.color, exp_col);
      chk("color_valid", bus.color_valid, exp_vld);
      chk("red_cnt", bus.red_cnt, exp_r);
      chk("green_cnt", bus.green_cnt, exp_g);
      chk("blue_cnt", bus.blue_cnt, exp_b);
      chk("s0s1", {bus.s0, bus.s1}, 2);
      if (!(running && off == SWEEP - 1)) chk("s2s3", {bus.s2, bus.s3}, sel);
      if (bus.color_valid) pulse_total++;
    end
  end

  typedef struct {int r; int g; int b;} sweep_t;
  sweep_t plan[$];

  task automatic add(input int r, input int g, input int b, input int n);
    for (int i = 0; i < n; i++) plan.push_back(sweep_t'{r, g, b});
  endtask

  function automatic logic pulse_at(input int k, input int r, input int g, input int b);
    int p = k / SW;
    int c = k % SW;
    int n;
    if (k >= 3 * SW) return 1'b0;
    n = (p == 0) ? r : (p == 1) ? g : b;
    return (c >= S && c < S + 2 * n && ((c - S) % 2 == 0));
  endfunction

  // Runs the plan from IDLE and leaves the bench just after the negedge where the last decision shows.
  task automatic run_case(input string name, input int exp_color, input int exp_pulses);
    int base = pulse_total;
    @(posedge clk); #1;
    bus.enable = 1'b1;
    foreach (plan[i]) begin
      for (int k = 0; k < SWEEP; k++) begin
        @(posedge clk); #1;
        if (k == 0) begin
          cur_r = plan[i].r; cur_g = plan[i].g; cur_b = plan[i].b;
        end
        bus.sensor_out = pulse_at(k, plan[i].r, plan[i].g, plan[i].b);
      end
    end
    @(posedge clk); #1;
    cur_r = 0; cur_g = 0; cur_b = 0;
    @(negedge clk); #1;
    chk({name, " color"}, bus.color, exp_color);
    chk({name, " pulses"}, pulse_total - base, exp_pulses);
    plan.delete();
  endtask

  task automatic stop_case();
    bus.enable = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.enable     = 1'b0;
    bus.sensor_out = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset color", bus.color, 0);
    chk("reset valid", bus.color_valid, 0);
    chk("reset s2s3", {bus.s2, bus.s3}, 0);
    chk("reset s0s1", {bus.s0, bus.s1}, 2);
    chk("reset red_cnt", bus.red_cnt, 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    add(10, 4, 3, 2);
    run_case("red", 1, 1);
    chk("red pulse now", bus.color_valid, 1);
    chk("red red_cnt", bus.red_cnt, 10);
    chk("red green_cnt", bus.green_cnt, 4);
    chk("red blue_cnt", bus.blue_cnt, 3);
    stop_case();

    add(3, 3, 3, 2);
    run_case("below thresh", 0, 0);
    stop_case();

    add(8, 8, 2, 2);
    run_case("tie rg", 1, 1);
    stop_case();

    add(1, 9, 9, 2);
    run_case("tie gb", 3, 1);
    stop_case();

    for (int i = 0; i < 3; i++) begin
      add(1, 12, 2, 1);
      add(1, 2, 12, 1);
    end
    run_case("flicker", 0, 0);
    stop_case();

    add(18, 2, 2, 1);
    run_case("sat", 0, 0);
    chk("sat red_cnt w4", bus4.red_cnt, 15);
    chk("sat green_cnt w4", bus4.green_cnt, 2);
    chk("sat red_cnt w8", bus.red_cnt, 18);
    stop_case();

    add(1, 12, 2, 2);
    run_case("green", 3, 1);
    repeat (60) @(posedge clk);
    #1;
    chk("abort pre color", bus.color, 3);
    chk("abort pre s2s3", {bus.s2, bus.s3}, 3);
    bus.enable = 1'b0;
    @(posedge clk); #1;
    chk("abort s2s3", {bus.s2, bus.s3}, 0);
    chk("abort color", bus.color, 0);
    chk("abort valid", bus.color_valid, 1);
    repeat (2) @(posedge clk);
    #1;

    add(10, 2, 2, 2);
    run_case("restart", 1, 1);
    repeat (132) @(posedge clk);
    #1;
    chk("pre-rst color", bus.color, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("rst color", bus.color, 0);
    chk("rst valid", bus.color_valid, 0);
    chk("rst s2s3", {bus.s2, bus.s3}, 0);
    chk("rst s0s1", {bus.s0, bus.s1}, 2);
    chk("rst red_cnt", bus.red_cnt, 0);
    chk("rst blue_cnt", bus.blue_cnt, 0);
    bus.enable = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
